// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared state encoding, default geometry and floor-to-y helper
package sim_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WALK_IN  = 2'd1,
    RIDE     = 2'd2,
    WALK_OUT = 2'd3
  } sim_state_t;

  localparam int unsigned DEF_STEP    = 2;
  localparam int unsigned DEF_LOBBY_X = 40;
  localparam int unsigned DEF_CAR_X   = 300;
  localparam int unsigned DEF_EXIT_X  = 600;
  localparam int unsigned DEF_Y_BASE  = 420;
  localparam int unsigned DEF_FLOOR_H = 60;

  // Floor 0 sits at the bottom; higher floors have smaller y on screen.
  function automatic logic [9:0] floor_y(input logic [2:0]  f,
                                         input int unsigned y_base,
                                         input int unsigned floor_h);
    return 10'(y_base - 32'(f) * floor_h);
  endfunction

endpackage

// File: rtl/coord_stepper.sv
// rtl/coord_stepper.sv - 10-bit coordinate that steps toward a target and clamps on it
module coord_stepper #(
  parameter int unsigned STEP      = 2,
  parameter logic [9:0]  RESET_VAL = 10'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       load,
  input  logic [9:0] load_val,
  input  logic [9:0] target,
  output logic [9:0] pos,
  output logic       arrived
);

  logic [9:0] pos_q, pos_d;
  logic [9:0] gap;
  logic [9:0] next_pos;

  // Distance is taken without wrap so the clamp decision never sees an overflowed sum.
  always_comb begin
    gap      = 10'd0;
    next_pos = pos_q;
    if (pos_q < target) begin
      gap      = target - pos_q;
      next_pos = (gap <= 10'(STEP)) ? target : pos_q + 10'(STEP);
    end else begin
      gap      = pos_q - target;
      next_pos = (gap <= 10'(STEP)) ? target : pos_q - 10'(STEP);
    end
    pos_d = pos_q;
    if (load) begin
      pos_d = load_val;
    end else if (en) begin
      pos_d = next_pos;
    end
  end

  // Position register; a load overrides the step so the caller can recycle the sprite.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q <= RESET_VAL;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos     = pos_q;
  assign arrived = en && (gap <= 10'(STEP));

endmodule

// File: rtl/person_animator.sv
// rtl/person_animator.sv - walks a sprite into the car, rides to a floor, walks it out
module person_animator import sim_pkg::*; #(
  parameter int unsigned STEP    = DEF_STEP,
  parameter int unsigned LOBBY_X = DEF_LOBBY_X,
  parameter int unsigned CAR_X   = DEF_CAR_X,
  parameter int unsigned EXIT_X  = DEF_EXIT_X,
  parameter int unsigned Y_BASE  = DEF_Y_BASE,
  parameter int unsigned FLOOR_H = DEF_FLOOR_H
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       req_valid,
  input  logic [2:0] req_floor,
  output logic       req_ready,
  output logic [1:0] sim_state,
  output logic [7:0] destination,
  output logic [9:0] xpos_person,
  output logic [9:0] ypos_person,
  output logic [2:0] cur_floor
);

  sim_state_t state_q, state_d;
  logic [2:0] dest_floor_q, dest_floor_d;
  logic [2:0] cur_floor_q, cur_floor_d;
  logic [7:0] destination_q, destination_d;

  logic       step;
  logic       x_en, x_load, x_arrived;
  logic       y_en, y_arrived;
  logic [9:0] x_target, y_target;

  assign step     = frame_tick && run && (state_q != IDLE);
  assign x_en     = step && ((state_q == WALK_IN) || (state_q == WALK_OUT));
  assign x_target = (state_q == WALK_OUT) ? 10'(EXIT_X) : 10'(CAR_X);
  assign x_load   = x_arrived && (state_q == WALK_OUT);
  assign y_en     = step && (state_q == RIDE);
  assign y_target = floor_y(dest_floor_q, Y_BASE, FLOOR_H);

  coord_stepper #(.STEP(STEP), .RESET_VAL(10'(LOBBY_X))) u_x (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (x_en),
    .load     (x_load),
    .load_val (10'(LOBBY_X)),
    .target   (x_target),
    .pos      (xpos_person),
    .arrived  (x_arrived)
  );

  coord_stepper #(.STEP(STEP), .RESET_VAL(10'(Y_BASE))) u_y (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (y_en),
    .load     (1'b0),
    .load_val (10'(Y_BASE)),
    .target   (y_target),
    .pos      (ypos_person),
    .arrived  (y_arrived)
  );

  // Next-state: accept only in IDLE, advance phases when the stepper lands on its target.
  always_comb begin
    state_d       = state_q;
    dest_floor_d  = dest_floor_q;
    cur_floor_d   = cur_floor_q;
    destination_d = destination_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          dest_floor_d  = req_floor;
          destination_d = 8'h01 << req_floor;
          state_d       = WALK_IN;
        end
      end
      WALK_IN: begin
        if (x_arrived) begin
          state_d = (dest_floor_q == cur_floor_q) ? WALK_OUT : RIDE;
        end
      end
      RIDE: begin
        if (y_arrived) begin
          cur_floor_d = dest_floor_q;
          state_d     = WALK_OUT;
        end
      end
      WALK_OUT: begin
        if (x_arrived) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset forgets any pending trip.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dest_floor_q  <= 3'd0;
      cur_floor_q   <= 3'd0;
      destination_q <= 8'h01;
    end else begin
      state_q       <= state_d;
      dest_floor_q  <= dest_floor_d;
      cur_floor_q   <= cur_floor_d;
      destination_q <= destination_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign sim_state   = state_q;
  assign destination = destination_q;
  assign cur_floor   = cur_floor_q;

endmodule

// File: tb/tb_person_animator.sv
// tb/tb_person_animator.sv - directed scoreboard bench for person_animator
module tb_person_animator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_floor = 3'd0;
  logic       req_ready;
  logic [1:0] sim_state;
  logic [7:0] destination;
  logic [9:0] xpos_person;
  logic [9:0] ypos_person;
  logic [2:0] cur_floor;

  person_animator dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .run         (run),
    .req_valid   (req_valid),
    .req_floor   (req_floor),
    .req_ready   (req_ready),
    .sim_state   (sim_state),
    .destination (destination),
    .xpos_person (xpos_person),
    .ypos_person (ypos_person),
    .cur_floor   (cur_floor)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic push_outs(input string p, input int st, input int x, input int y,
                           input int dest, input int cf, input int rdy);
    push({p, ".state"}, 32'(st));
    push({p, ".x"}, 32'(x));
    push({p, ".y"}, 32'(y));
    push({p, ".dest"}, 32'(dest));
    push({p, ".cur_floor"}, 32'(cf));
    push({p, ".ready"}, 32'(rdy));
  endtask

  task automatic pop_outs();
    pop_check(32'(sim_state));
    pop_check(32'(xpos_person));
    pop_check(32'(ypos_person));
    pop_check(32'(destination));
    pop_check(32'(cur_floor));
    pop_check(32'(req_ready));
  endtask

  // Invariant: entered and left at posedge+1; one tick every 4 clocks.
  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic count_ticks(input int st, input int max, output int cnt);
    cnt = 0;
    while (int'(sim_state) == st && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  task automatic request(input logic [2:0] f, input logic with_tick);
    req_valid  = 1'b1;
    req_floor  = f;
    frame_tick = with_tick;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic full_trip(input string p, input int walk_in, input int ride,
                           input int st_after_in);
    push({p, ".walk_in_ticks"}, 32'(walk_in));
    count_ticks(1, 400, n);
    pop_check(32'(n));
    push({p, ".state_after_walk_in"}, 32'(st_after_in));
    pop_check(32'(sim_state));
    if (st_after_in == 2) begin
      push({p, ".ride_ticks"}, 32'(ride));
      count_ticks(2, 400, n);
      pop_check(32'(n));
    end
    push({p, ".walk_out_ticks"}, 32'd150);
    count_ticks(3, 400, n);
    pop_check(32'(n));
  endtask

  initial begin
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push_outs("reset", 0, 40, 420, 8'h01, 0, 1);
    @(posedge clk); #1;
    pop_outs();

    // Floor 0 -> 5, with dropped request and run freeze in the middle of RIDE.
    push_outs("accept5", 1, 40, 420, 8'h20, 0, 0);
    request(3'd5, 1'b0);
    pop_outs();
    push("t1.walk_in_ticks", 32'd130);
    count_ticks(1, 400, n);
    pop_check(32'(n));
    push_outs("t1.ride_start", 2, 300, 420, 8'h20, 0, 0);
    pop_outs();
    repeat (10) tick();
    push_outs("t1.drop_req", 2, 300, 400, 8'h20, 0, 0);
    request(3'd2, 1'b0);
    pop_outs();
    run = 1'b0;
    repeat (20) tick();
    push_outs("t1.frozen", 2, 300, 400, 8'h20, 0, 0);
    pop_outs();
    run = 1'b1;
    push("t1.ride_rest_ticks", 32'd140);
    count_ticks(2, 400, n);
    pop_check(32'(n));
    push_outs("t1.walk_out_start", 3, 300, 120, 8'h20, 5, 0);
    pop_outs();
    push("t1.walk_out_ticks", 32'd150);
    count_ticks(3, 400, n);
    pop_check(32'(n));
    push_outs("t1.idle", 0, 40, 120, 8'h20, 5, 1);
    pop_outs();

    // Same floor: WALK_IN goes straight to WALK_OUT.
    request(3'd5, 1'b0);
    full_trip("same5", 130, 0, 3);
    push_outs("same5.idle", 0, 40, 120, 8'h20, 5, 1);
    pop_outs();

    // Acceptance coincident with a tick does not move the sprite.
    req_valid  = 1'b1;
    req_floor  = 3'd7;
    frame_tick = 1'b1;
    push_outs("acc_tick", 1, 40, 120, 8'h80, 5, 0);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    frame_tick = 1'b0;
    pop_outs();
    repeat (3) @(posedge clk);
    #1;
    full_trip("to7", 130, 60, 2);
    push_outs("to7.idle", 0, 40, 0, 8'h80, 7, 1);
    pop_outs();

    // Floor 7 -> 0, the longest ride.
    request(3'd0, 1'b0);
    full_trip("to0", 130, 210, 2);
    push_outs("to0.idle", 0, 40, 420, 8'h01, 0, 1);
    pop_outs();

    // Asynchronous reset in the middle of a ride.
    request(3'd3, 1'b0);
    count_ticks(1, 400, n);
    repeat (5) tick();
    push_outs("midride", 2, 300, 410, 8'h08, 0, 0);
    pop_outs();
    push_outs("async_reset", 0, 40, 420, 8'h01, 0, 1);
    reset_n = 1'b0;
    #1;
    pop_outs();
    @(posedge clk); #1;
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
